// File: rtl/lbp_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared types and constants for the streaming LBP engine:
//                FSM state encoding and neighbour-bit to window-tap mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Window taps are numbered row-major: tap = (dr+1)*3 + (dc+1).
    localparam int C_NB_COUNT   = 8;
    localparam int C_TAP_CENTRE = 4;

    // Tap feeding each LBP code bit (bit0 = (-1,-1) ... bit7 = (+1,+1)).
    localparam int C_NB_TAP [C_NB_COUNT] = '{0, 1, 2, 3, 5, 6, 7, 8};

endpackage : lbp_pkg
`default_nettype wire

// File: rtl/lbp_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_stream_if
//  Description : Host-read and result-write signals of the LBP engine.
//                master = engine side, slave = memory/sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lbp_stream_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          gray_ready;
    logic [DW-1:0] thr;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic          lbp_ready;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    modport master (
        input  gray_ready, thr, gray_data, lbp_ready,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, thr, gray_data, lbp_ready,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface : lbp_stream_if
`default_nettype wire

// File: rtl/lbp_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_line_buffer
//  Description : Two IMG_W-deep row delay lines plus a 3x3 window. The two
//                older window columns are registered; the newest column is
//                taken live from the delay-line outputs and the incoming
//                pixel, so the full window is visible in the cycle the
//                bottom-right pixel arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_line_buffer #(
    parameter int IMG_W = 128,
    parameter int DW    = 8,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                shift_en,
    input  logic [DW-1:0]       din,
    input  logic [CW-1:0]       col,
    output logic [8:0][DW-1:0]  taps
);

    // Circular row stores indexed by column: r_row1 holds row r-1, r_row2 row r-2.
    logic [DW-1:0] r_row1 [IMG_W];
    logic [DW-1:0] r_row2 [IMG_W];
    // r_win[row][0] = column c-2, r_win[row][1] = column c-1.
    logic [DW-1:0] r_win  [3][2];
    logic [DW-1:0] w_col  [3];

    assign w_col[0] = r_row2[col];
    assign w_col[1] = r_row1[col];
    assign w_col[2] = din;

    // Push the new pixel into row r-1 store and cascade the old entry to row r-2.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            r_row1[col] <= din;
            r_row2[col] <= r_row1[col];
        end
    end

    // Slide the window one column left.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= w_col[i];
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_tap
        assign taps[3*i+0] = r_win[i][0];
        assign taps[3*i+1] = r_win[i][1];
        assign taps[3*i+2] = w_col[i];
    end

endmodule : lbp_line_buffer
`default_nettype wire

// File: rtl/lbp_stream.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_stream
//  Description : Streaming Local Binary Pattern engine. Reads every pixel
//                once in raster order, builds 3x3 windows in line buffers
//                and emits one code per interior pixel with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    lbp_stream_if.master  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] C_LAST_ADDR   = AW'(IMG_W*IMG_H - 1);
    localparam logic [AW-1:0] C_LAST_CENTRE = AW'((IMG_H-2)*IMG_W + IMG_W - 2);
    localparam logic [AW-1:0] C_CENTRE_OFS  = AW'(IMG_W + 1);

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_gaddr;
    logic             r_inflight;
    logic             r_skid_valid;
    logic [DW-1:0]    r_skid_data;
    logic [DW-1:0]    r_thr;
    logic [CW-1:0]    r_pcol;
    logic [RW-1:0]    r_prow;
    logic [AW-1:0]    r_paddr;
    logic             r_lbp_valid;
    logic [AW-1:0]    r_lbp_addr;
    logic [7:0]       r_lbp_data;
    logic             r_finish;

    logic             w_out_free;
    logic             w_req;
    logic             w_pix_avail;
    logic [DW-1:0]    w_pix;
    logic             w_consume;
    logic             w_emit;
    logic [8:0][DW-1:0] w_taps;
    logic [DW:0]      w_ref;
    logic [7:0]       w_code;

    // The output slot can take a new code if empty or being drained this cycle.
    assign w_out_free  = !r_lbp_valid || bus.lbp_ready;
    // A read is issued only when the skid is empty and the output is not blocked,
    // so at most one pixel can ever be pending in the skid.
    assign w_req       = (r_state == RUN) && w_out_free && !r_skid_valid;
    // The skid is always older than any returning read, so it wins.
    assign w_pix_avail = r_skid_valid || r_inflight;
    assign w_pix       = r_skid_valid ? r_skid_data : bus.gray_data;
    assign w_consume   = w_pix_avail && w_out_free;
    assign w_emit      = w_consume && (r_prow >= RW'(2)) && (r_pcol >= CW'(2));

    lbp_line_buffer #(
        .IMG_W (IMG_W),
        .DW    (DW),
        .CW    (CW)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (w_consume),
        .din      (w_pix),
        .col      (r_pcol),
        .taps     (w_taps)
    );

    // Centre plus threshold in DW+1 bits: a saturating-free sum means any
    // reference above the pixel range simply yields a 0 bit.
    assign w_ref = {1'b0, w_taps[C_TAP_CENTRE]} + {1'b0, r_thr};

    for (genvar i = 0; i < C_NB_COUNT; i++) begin : g_cmp
        assign w_code[i] = ({1'b0, w_taps[C_NB_TAP[i]]} >= w_ref);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (bus.gray_ready) w_state_nxt = RUN;
            RUN:   if (w_req && (r_gaddr == C_LAST_ADDR)) w_state_nxt = DRAIN;
            DRAIN: if (r_lbp_valid && bus.lbp_ready && (r_lbp_addr == C_LAST_CENTRE))
                       w_state_nxt = DONE;
            DONE:  w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read address counter, read-in-flight flag and threshold capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gaddr    <= '0;
            r_inflight <= 1'b0;
            r_thr      <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req && (r_gaddr != C_LAST_ADDR))
                r_gaddr <= r_gaddr + AW'(1);
            if ((r_state == IDLE) && bus.gray_ready)
                r_thr <= bus.thr;
        end
    end

    // Skid register catches a returning pixel that cannot be consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_skid_valid) begin
            if (w_consume) r_skid_valid <= 1'b0;
        end else if (r_inflight && !w_consume) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= bus.gray_data;
        end
    end

    // Position of the next pixel to enter the line buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcol  <= '0;
            r_prow  <= '0;
            r_paddr <= '0;
        end else if (w_consume) begin
            r_paddr <= r_paddr + AW'(1);
            if (r_pcol == CW'(IMG_W-1)) begin
                r_pcol <= '0;
                r_prow <= r_prow + RW'(1);
            end else begin
                r_pcol <= r_pcol + CW'(1);
            end
        end
    end

    // Output register: load a completed window's code, else drain on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lbp_valid <= 1'b0;
            r_lbp_addr  <= '0;
            r_lbp_data  <= '0;
        end else if (w_emit) begin
            r_lbp_valid <= 1'b1;
            r_lbp_addr  <= r_paddr - C_CENTRE_OFS;
            r_lbp_data  <= w_code;
        end else if (bus.lbp_ready) begin
            r_lbp_valid <= 1'b0;
        end
    end

    // Frame-done flag, one cycle behind entry into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_finish <= 1'b0;
        else       r_finish <= (r_state == DONE);
    end

    assign bus.gray_req  = w_req;
    assign bus.gray_addr = r_gaddr;
    assign bus.lbp_valid = r_lbp_valid;
    assign bus.lbp_addr  = r_lbp_addr;
    assign bus.lbp_data  = r_lbp_data;
    assign bus.finish    = r_finish;

endmodule : lbp_stream
`default_nettype wire

// File: tb/tb_lbp_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbp_stream
//  Description : Self-checking bench for lbp_stream on an 8x6 image with a
//                host-memory model and a reference LBP model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_stream;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W*H;
    localparam int NEXP = (W-2)*(H-2);
    localparam int AWT  = 6;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] img [NPIX];
    int         exp_addr [$];
    int         exp_code [$];

    lbp_stream_if #(.DW(8), .AW(AWT)) bus ();

    lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(AWT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference LBP code for centre (r,c) straight from the bit-map definition.
    function automatic int ref_code(input int r, input int c, input int t);
        int dr [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
        int dc [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};
        int code = 0;
        int cen  = int'(img[r*W + c]);
        for (int b = 0; b < 8; b++) begin
            if (int'(img[(r+dr[b])*W + c + dc[b]]) >= cen + t)
                code |= (1 << b);
        end
        return code;
    endfunction

    task automatic build_expected(input int t);
        exp_addr.delete();
        exp_code.delete();
        for (int r = 1; r < H-1; r++)
            for (int c = 1; c < W-1; c++) begin
                exp_addr.push_back(r*W + c);
                exp_code.push_back(ref_code(r, c, t));
            end
    endtask

    // mode 0: always ready; 1: random ready; 2: ready held low 20 cycles mid-row.
    // abort_at > 0: assert reset right after that many transfers.
    task automatic run_frame(input int thr_v, input int mode, input int abort_at);
        int ntr = 0, cyc = 0, hold_cnt = 0, exp_gaddr = 0;
        int req_cyc = -1, first_v = -1;
        bit done = 0;
        logic pend_req = 1'b0;
        logic [AWT-1:0] pend_addr = '0;
        logic prev_stall = 1'b0;
        logic [AWT-1:0] prev_addr = '0;
        logic [7:0] prev_data = '0;

        build_expected(thr_v);
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        bus.lbp_ready  = 1'b0;
        bus.thr        = '0;
        bus.gray_data  = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gray_req",  bus.gray_req,  0);
            chk("rst_gray_addr", bus.gray_addr, 0);
            chk("rst_lbp_valid", bus.lbp_valid, 0);
            chk("rst_lbp_addr",  bus.lbp_addr,  0);
            chk("rst_lbp_data",  bus.lbp_data,  0);
            chk("rst_finish",    bus.finish,    0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.gray_ready = 1'b1;
        bus.thr = thr_v[7:0];

        while (ntr < NEXP && cyc < 3000 && !done) begin
            case (mode)
                1: bus.lbp_ready = 1'($urandom_range(0, 1));
                2: if (ntr >= 3 && hold_cnt < 20) begin
                       bus.lbp_ready = 1'b0;
                       hold_cnt++;
                   end else begin
                       bus.lbp_ready = 1'b1;
                   end
                default: bus.lbp_ready = 1'b1;
            endcase
            bus.gray_data = pend_req ? img[pend_addr] : 8'($urandom);
            if (cyc == 3) begin
                bus.gray_ready = 1'b0;
                bus.thr = 8'($urandom);
            end
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_valid", bus.lbp_valid, 1);
                chk("hold_addr",  bus.lbp_addr,  prev_addr);
                chk("hold_data",  bus.lbp_data,  prev_data);
            end
            if (bus.lbp_valid && !bus.lbp_ready)
                chk("stall_gray_req", bus.gray_req, 0);
            chk("finish_early", bus.finish, 0);
            if (bus.gray_req) begin
                if (exp_gaddr == 2*W + 2) req_cyc = cyc;
                chk("gray_addr", bus.gray_addr, exp_gaddr);
                exp_gaddr++;
            end
            if (bus.lbp_valid && first_v < 0) begin
                first_v = cyc;
                if (mode == 0) chk("first_latency", first_v - req_cyc, 2);
            end
            if (bus.lbp_valid && bus.lbp_ready) begin
                if (ntr < NEXP) begin
                    chk("lbp_addr", bus.lbp_addr, exp_addr[ntr]);
                    chk("lbp_data", bus.lbp_data, exp_code[ntr]);
                end else begin
                    chk("extra_transfer", ntr, NEXP);
                end
                ntr++;
            end
            prev_stall = bus.lbp_valid && !bus.lbp_ready;
            prev_addr  = bus.lbp_addr;
            prev_data  = bus.lbp_data;
            pend_req   = bus.gray_req;
            pend_addr  = bus.gray_addr;
            @(posedge clk); #1;
            cyc++;
            if (abort_at > 0 && ntr == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_lbp_valid", bus.lbp_valid, 0);
                chk("abort_gray_req",  bus.gray_req,  0);
                chk("abort_finish",    bus.finish,    0);
                done = 1;
            end
        end

        if (!done) begin
            chk("transfer_count", ntr, NEXP);
            bus.lbp_ready = 1'b1;
            @(posedge clk); #1;
            repeat (3) begin
                @(negedge clk);
                chk("finish_held",    bus.finish,    1);
                chk("done_lbp_valid", bus.lbp_valid, 0);
                chk("done_gray_req",  bus.gray_req,  0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        bus.lbp_ready  = 1'b0;
        bus.thr        = '0;
        bus.gray_data  = '0;

        // Ramp image: gray[a] = a, several thresholds including overflow.
        for (int a = 0; a < NPIX; a++) img[a] = 8'(a);
        run_frame(0,   0, 0);
        run_frame(9,   0, 0);
        run_frame(255, 0, 0);

        // Random image with random backpressure.
        for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
        run_frame(int'($urandom_range(0, 15)), 1, 0);

        // Long ready-low hold in the middle of a row.
        for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
        run_frame(3, 2, 0);

        // Flat images: all-ones codes, and a centre of 255 with thr=1.
        for (int a = 0; a < NPIX; a++) img[a] = 8'h80;
        run_frame(0, 0, 0);
        for (int a = 0; a < NPIX; a++) img[a] = 8'hFF;
        run_frame(1, 1, 0);

        // Reset after 10 transfers, then a full clean frame.
        for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
        run_frame(0, 1, 10);
        run_frame(0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lbp_stream
`default_nettype wire
